vc_pop_arbiter: RTL and testbench

VC_POP_ARBITER -- requirements
Module: vc_pop_arbiter

---
 rtl/vc_pkg.sv | 45 ++++
 rtl/vc_grant.sv | 52 +++++
 rtl/vc_pop_arbiter.sv | 160 ++++++++++++++++
 tb/tb_vc_pop_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_pkg.sv
// ----------------------------------------------------------------------------
// vc_pkg
// Shared definitions for the virtual-channel pop arbiter and the VC FIFO
// wrappers: FSM state encodings, grant-streak width, default VC0 weight, the
// pop-tag record carried down the delivery pipeline, and the streak update rule.
// ----------------------------------------------------------------------------
package vc_pkg;

    // Encoding 2'd3 is unused; the arbiter decodes it back to StIdle.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StActive = 2'd1,
        StStall  = 2'd2
    } vc_state_e;

    localparam int unsigned StreakW       = 3;
    localparam int unsigned DefaultWeight = 4;
    localparam int unsigned PopCntW       = 8;

    // One entry of the pop-tag pipeline: was a word popped, and from which VC.
    typedef struct packed {
        logic vld;
        logic vc;   // 0: VC0, 1: VC1
    } pop_tag_t;

    // Next value of the VC0 grant streak. The streak only means something while
    // VC1 is waiting, so it is cleared whenever VC1 is empty or gets served.
    function automatic logic [StreakW-1:0] streak_next(
        input logic [StreakW-1:0] cur,
        input logic [StreakW-1:0] weight,
        input logic               vc1_empty,
        input logic               gnt_vc0,
        input logic               gnt_vc1
    );
        logic [StreakW-1:0] nxt;
        nxt = cur;
        if (vc1_empty || gnt_vc1) begin
            nxt = '0;
        end else if (gnt_vc0 && (cur != weight)) begin
            nxt = cur + 1'b1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/vc_grant.sv
// ----------------------------------------------------------------------------
// vc_grant
// Two-way grant between VC0 and VC1. VC0 has strict priority, but once VC0 has
// been granted WEIGHT times in a row while VC1 waits, VC1 gets the next slot.
// Grants are combinational; the only state is the streak counter.
//
// Ports
//   clk          clock
//   reset        synchronous active-high reset (clears the streak)
//   i_pop_en     a pop may be issued this cycle (arbiter ACTIVE, not throttled)
//   i_vc0_empty  VC0 FIFO empty flag
//   i_vc1_empty  VC1 FIFO empty flag
//   o_gnt_vc0    pop VC0 this cycle
//   o_gnt_vc1    pop VC1 this cycle
// ----------------------------------------------------------------------------
module vc_grant
    import vc_pkg::*;
#(
    parameter int unsigned WEIGHT = DefaultWeight
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pop_en,
    input  logic i_vc0_empty,
    input  logic i_vc1_empty,
    output logic o_gnt_vc0,
    output logic o_gnt_vc1
);

    localparam logic [StreakW-1:0] WeightQ = StreakW'(WEIGHT);

    logic [StreakW-1:0] r_streak;
    logic [StreakW-1:0] w_streak_next;
    logic               w_force_vc1;

    always_comb begin
        w_force_vc1   = (r_streak == WeightQ) && !i_vc1_empty;
        // VC1 wins when VC0 has nothing, or when VC0 has used up its streak.
        o_gnt_vc1     = i_pop_en && !i_vc1_empty && (i_vc0_empty || w_force_vc1);
        o_gnt_vc0     = i_pop_en && !i_vc0_empty && !o_gnt_vc1;
        w_streak_next = streak_next(r_streak, WeightQ, i_vc1_empty, o_gnt_vc0, o_gnt_vc1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_streak <= '0;
        end else begin
            r_streak <= w_streak_next;
        end
    end

endmodule

// File: rtl/vc_pop_arbiter.sv
// ----------------------------------------------------------------------------
// vc_pop_arbiter
// Pops words from two virtual-channel FIFOs (VC0, VC1) and forwards them to a
// downstream FIFO. A three-state FSM (IDLE/ACTIVE/STALL) gates popping on the
// downstream almost-full flag; vc_grant picks which VC is popped. A pop at
// cycle N yields valid_out at N+2 with the word taken from the popped VC.
//
// Ports
//   clk            clock
//   reset          synchronous active-high reset; drops in-flight words
//   VC0_data_out   VC0 read data, valid the cycle after VC0_rd
//   VC0_empty      VC0 empty flag
//   VC1_data_out   VC1 read data, valid the cycle after VC1_rd
//   VC1_empty      VC1 empty flag
//   D_almost_full  downstream almost-full; stops new pops immediately
//   VC0_rd         pop strobe to VC0 (combinational)
//   VC1_rd         pop strobe to VC1 (combinational)
//   data_out       registered popped word, holds when valid_out is low
//   valid_out      one-cycle qualifier per delivered word
//   state_out      current FSM state encoding
//   pop_cnt_vc0    wrapping count of VC0 words delivered
//   pop_cnt_vc1    wrapping count of VC1 words delivered
// ----------------------------------------------------------------------------
module vc_pop_arbiter
    import vc_pkg::*;
#(
    parameter int unsigned BW     = 6,
    parameter int unsigned WEIGHT = DefaultWeight
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [BW-1:0]      VC0_data_out,
    input  logic               VC0_empty,
    input  logic [BW-1:0]      VC1_data_out,
    input  logic               VC1_empty,
    input  logic               D_almost_full,
    output logic               VC0_rd,
    output logic               VC1_rd,
    output logic [BW-1:0]      data_out,
    output logic               valid_out,
    output logic [1:0]         state_out,
    output logic [PopCntW-1:0] pop_cnt_vc0,
    output logic [PopCntW-1:0] pop_cnt_vc1
);

    vc_state_e          r_state;
    vc_state_e          w_state_next;
    logic               w_any_ready;
    logic               w_pop_en;
    logic               w_gnt_vc0;
    logic               w_gnt_vc1;
    pop_tag_t           w_tag_in;
    pop_tag_t           r_tag_s1;   // popped this cycle, FIFO data arrives next
    pop_tag_t           r_tag_s2;   // word currently on data_out
    logic [BW-1:0]      r_data_out;
    logic [PopCntW-1:0] r_pop_cnt_vc0;
    logic [PopCntW-1:0] r_pop_cnt_vc1;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_any_ready  = !VC0_empty || !VC1_empty;
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_any_ready) begin
                    w_state_next = D_almost_full ? StStall : StActive;
                end
            end
            StActive: begin
                if (D_almost_full) begin
                    w_state_next = StStall;
                end else if (!w_any_ready) begin
                    w_state_next = StIdle;
                end
            end
            StStall: begin
                if (!D_almost_full) begin
                    w_state_next = w_any_ready ? StActive : StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        // Reset gates the strobes directly so nothing is popped in a reset cycle.
        w_pop_en  = (r_state == StActive) && !D_almost_full && !reset;
        VC0_rd    = w_gnt_vc0;
        VC1_rd    = w_gnt_vc1;
        state_out = r_state;
    end

    vc_grant #(
        .WEIGHT (WEIGHT)
    ) u_grant (
        .clk         (clk),
        .reset       (reset),
        .i_pop_en    (w_pop_en),
        .i_vc0_empty (VC0_empty),
        .i_vc1_empty (VC1_empty),
        .o_gnt_vc0   (w_gnt_vc0),
        .o_gnt_vc1   (w_gnt_vc1)
    );

    // ------------------------------------------------------------------------
    // Delivery datapath: tag pipeline, output register, per-VC counters
    // ------------------------------------------------------------------------
    always_comb begin
        w_tag_in.vld = w_gnt_vc0 || w_gnt_vc1;
        w_tag_in.vc  = w_gnt_vc1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag_s1      <= '0;
            r_tag_s2      <= '0;
            r_data_out    <= '0;
            r_pop_cnt_vc0 <= '0;
            r_pop_cnt_vc1 <= '0;
        end else begin
            r_tag_s1 <= w_tag_in;
            r_tag_s2 <= r_tag_s1;
            // FIFO read data is valid exactly one cycle after the pop.
            if (r_tag_s1.vld) begin
                r_data_out <= r_tag_s1.vc ? VC1_data_out : VC0_data_out;
            end
            if (r_tag_s2.vld) begin
                if (r_tag_s2.vc) begin
                    r_pop_cnt_vc1 <= r_pop_cnt_vc1 + 1'b1;
                end else begin
                    r_pop_cnt_vc0 <= r_pop_cnt_vc0 + 1'b1;
                end
            end
        end
    end

    always_comb begin
        data_out    = r_data_out;
        valid_out   = r_tag_s2.vld;
        pop_cnt_vc0 = r_pop_cnt_vc0;
        pop_cnt_vc1 = r_pop_cnt_vc1;
    end

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// ----------------------------------------------------------------------------
// tb_vc_pop_arbiter
// Directed bench for vc_pop_arbiter. The two VC FIFOs are modelled with queues
// that respond to the pop strobes; inputs change just after the falling edge.
// ----------------------------------------------------------------------------
module tb_vc_pop_arbiter;

    localparam int unsigned BW     = 6;
    localparam int unsigned WEIGHT = 4;

    logic          clk;
    logic          reset;
    logic [BW-1:0] VC0_data_out;
    logic          VC0_empty;
    logic [BW-1:0] VC1_data_out;
    logic          VC1_empty;
    logic          D_almost_full;
    logic          VC0_rd;
    logic          VC1_rd;
    logic [BW-1:0] data_out;
    logic          valid_out;
    logic [1:0]    state_out;
    logic [7:0]    pop_cnt_vc0;
    logic [7:0]    pop_cnt_vc1;

    int n_tests;
    int n_fail;

    int q0[$];     // VC0 FIFO contents
    int q1[$];     // VC1 FIFO contents
    int got[$];    // words seen on valid_out
    int glog[$];   // grant log: 0 = VC0, 1 = VC1
    logic rd0_s;
    logic rd1_s;

    vc_pop_arbiter #(
        .BW     (BW),
        .WEIGHT (WEIGHT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .VC0_data_out  (VC0_data_out),
        .VC0_empty     (VC0_empty),
        .VC1_data_out  (VC1_data_out),
        .VC1_empty     (VC1_empty),
        .D_almost_full (D_almost_full),
        .VC0_rd        (VC0_rd),
        .VC1_rd        (VC1_rd),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .state_out     (state_out),
        .pop_cnt_vc0   (pop_cnt_vc0),
        .pop_cnt_vc1   (pop_cnt_vc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int got_at(input int i);
        return (i < got.size()) ? got[i] : -1;
    endfunction

    function automatic int glog_at(input int i);
        return (i < glog.size()) ? glog[i] : -1;
    endfunction

    task automatic refresh_empty();
        VC0_empty = (q0.size() == 0);
        VC1_empty = (q1.size() == 0);
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step();
        #2;
        rd0_s = VC0_rd;
        rd1_s = VC1_rd;
        check("rd_onehot", int'(VC0_rd & VC1_rd), 0);
        if (VC0_rd) glog.push_back(0);
        if (VC1_rd) glog.push_back(1);
        if (valid_out) got.push_back(int'(data_out));
        @(posedge clk);
        @(negedge clk);
        if (rd0_s && q0.size() > 0) VC0_data_out = BW'(q0.pop_front());
        if (rd1_s && q1.size() > 0) VC1_data_out = BW'(q1.pop_front());
        refresh_empty();
        #1;
    endtask

    int exp2[20] = '{'h00, 'h01, 'h02, 'h03, 'h20, 'h04, 'h05, 'h06, 'h07, 'h21,
                     'h08, 'h09, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h28, 'h29};
    int gexp2[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int exp39[7]  = '{'h01, 'h02, 'h03, 'h31, 'h32, 'h33, 'h34};

    initial begin
        int n;
        int nbad;
        n_tests       = 0;
        n_fail        = 0;
        reset         = 1'b1;
        VC0_data_out  = '0;
        VC1_data_out  = '0;
        VC0_empty     = 1'b1;
        VC1_empty     = 1'b1;
        D_almost_full = 1'b0;
        @(negedge clk);
        #1;
        step();
        step();

        // Reset state
        check("rst_state", int'(state_out), 0);
        check("rst_valid", int'(valid_out), 0);
        check("rst_data", int'(data_out), 0);
        check("rst_cnt0", int'(pop_cnt_vc0), 0);
        check("rst_cnt1", int'(pop_cnt_vc1), 0);
        reset = 1'b0;

        // Three VC0 words, VC1 empty
        q0 = '{'h11, 'h22, 'h33};
        refresh_empty();
        #1;
        check("t1_c0_state", int'(state_out), 0);
        step();
        check("t1_c1_state", int'(state_out), 1);
        check("t1_c1_rd0", int'(VC0_rd), 1);
        check("t1_c1_rd1", int'(VC1_rd), 0);
        step();
        check("t1_c2_rd0", int'(VC0_rd), 1);
        check("t1_c2_valid", int'(valid_out), 0);
        step();
        check("t1_c3_rd0", int'(VC0_rd), 1);
        check("t1_c3_valid", int'(valid_out), 1);
        check("t1_c3_data", int'(data_out), 'h11);
        step();
        check("t1_c4_rd0", int'(VC0_rd), 0);
        check("t1_c4_data", int'(data_out), 'h22);
        check("t1_c4_state", int'(state_out), 1);
        step();
        check("t1_c5_valid", int'(valid_out), 1);
        check("t1_c5_data", int'(data_out), 'h33);
        check("t1_c5_state", int'(state_out), 0);
        step();
        check("t1_c6_valid", int'(valid_out), 0);
        check("t1_c6_hold", int'(data_out), 'h33);
        check("t1_c6_cnt0", int'(pop_cnt_vc0), 3);

        // Both VCs with 10 words, weighted grant pattern
        got.delete();
        glog.delete();
        for (int i = 0; i < 10; i++) begin
            q0.push_back('h00 + i);
            q1.push_back('h20 + i);
        end
        refresh_empty();
        #1;
        n = 0;
        while (got.size() < 20 && n < 60) begin
            step();
            n++;
        end
        check("t2_count", got.size(), 20);
        for (int i = 0; i < 10; i++) check("t2_grant", glog_at(i), gexp2[i]);
        for (int i = 0; i < 20; i++) check("t2_data", got_at(i), exp2[i]);
        step();
        step();
        check("t2_state", int'(state_out), 0);
        check("t2_cnt0", int'(pop_cnt_vc0), 13);
        check("t2_cnt1", int'(pop_cnt_vc1), 10);

        // Streak at 3 then VC0 drains: VC1 every cycle, streak cleared
        got.delete();
        glog.delete();
        q0 = '{'h01, 'h02, 'h03};
        q1 = '{'h31, 'h32, 'h33, 'h34};
        refresh_empty();
        #1;
        step();
        step();
        step();
        step();
        check("t3_streak3", int'(dut.u_grant.r_streak), 3);
        check("t3_c4_rd1", int'(VC1_rd), 1);
        check("t3_c4_rd0", int'(VC0_rd), 0);
        step();
        check("t3_streak0", int'(dut.u_grant.r_streak), 0);
        check("t3_c5_rd1", int'(VC1_rd), 1);
        n = 0;
        while (got.size() < 7 && n < 40) begin
            step();
            n++;
        end
        check("t3_count", got.size(), 7);
        for (int i = 0; i < 7; i++) check("t3_grant", glog_at(i), (i < 3) ? 0 : 1);
        for (int i = 0; i < 7; i++) check("t3_data", got_at(i), exp39[i]);
        step();
        step();
        check("t3_state", int'(state_out), 0);
        check("t3_cnt0", int'(pop_cnt_vc0), 16);
        check("t3_cnt1", int'(pop_cnt_vc1), 14);

        // Downstream almost-full during continuous popping
        got.delete();
        glog.delete();
        for (int i = 0; i < 8; i++) q0.push_back('h10 + i);
        refresh_empty();
        #1;
        step();
        step();
        step();
        D_almost_full = 1'b1;
        #1;
        check("t4_c3_rd0", int'(VC0_rd), 0);
        check("t4_c3_data", int'(data_out), 'h10);
        step();
        check("t4_c4_state", int'(state_out), 2);
        check("t4_c4_valid", int'(valid_out), 1);
        check("t4_c4_data", int'(data_out), 'h11);
        step();
        check("t4_c5_valid", int'(valid_out), 0);
        step();
        check("t4_c6_valid", int'(valid_out), 0);
        check("t4_c6_state", int'(state_out), 2);
        D_almost_full = 1'b0;
        #1;
        check("t4_c6_rd0", int'(VC0_rd), 0);
        step();
        check("t4_c7_state", int'(state_out), 1);
        check("t4_c7_rd0", int'(VC0_rd), 1);
        n = 0;
        while (got.size() < 8 && n < 40) begin
            step();
            n++;
        end
        step();
        step();
        check("t4_count", got.size(), 8);
        for (int i = 0; i < 8; i++) check("t4_data", got_at(i), 'h10 + i);
        check("t4_state", int'(state_out), 0);
        check("t4_cnt0", int'(pop_cnt_vc0), 24);

        // Reset with pops in flight
        got.delete();
        q0 = '{'h2A, 'h2B, 'h2C, 'h2D};
        refresh_empty();
        #1;
        step();
        step();
        step();
        check("t5_c3_data", int'(data_out), 'h2A);
        reset = 1'b1;
        #1;
        check("t5_rst_rd0", int'(VC0_rd), 0);
        step();
        q0.delete();
        refresh_empty();
        check("t5_c4_valid", int'(valid_out), 0);
        check("t5_c4_state", int'(state_out), 0);
        step();
        reset = 1'b0;
        got.delete();
        for (int i = 0; i < 4; i++) step();
        check("t5_got", got.size(), 0);
        check("t5_valid", int'(valid_out), 0);
        check("t5_data", int'(data_out), 0);
        check("t5_state", int'(state_out), 0);
        check("t5_cnt0", int'(pop_cnt_vc0), 0);
        check("t5_cnt1", int'(pop_cnt_vc1), 0);

        // 260 VC0 words: counter wraps to 4
        got.delete();
        for (int i = 0; i < 260; i++) q0.push_back(i % 64);
        refresh_empty();
        #1;
        n = 0;
        while (got.size() < 260 && n < 600) begin
            step();
            n++;
        end
        step();
        step();
        check("t6_count", got.size(), 260);
        nbad = 0;
        for (int i = 0; i < 260; i++) if (got_at(i) != (i % 64)) nbad++;
        check("t6_order", nbad, 0);
        check("t6_cnt0", int'(pop_cnt_vc0), 4);
        check("t6_cnt1", int'(pop_cnt_vc1), 0);
        check("t6_state", int'(state_out), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
